// File: rtl/token_injector_if.sv
// Handshake bundle between a token_injector, the boot scheduler, the local sample
// source and the NoC injection port.
interface token_injector_if #(
  parameter int unsigned FLIT_W = 32
) ();
  logic              TokenValid_i;
  logic              TokenReady_o;
  logic [3:0]        Id_i;
  logic              SrcValid_i;
  logic [FLIT_W-1:0] SrcData_i;
  logic              SrcReady_o;
  logic              FlitValid_o;
  logic [FLIT_W+1:0] FlitData_o;
  logic              FlitReady_i;
  logic              Busy_o;
  logic [15:0]       Seq_o;
  logic              Underrun_o;
  logic              Overlap_o;

  // Injector side.
  modport slave (
    input  TokenValid_i, Id_i, SrcValid_i, SrcData_i, FlitReady_i,
    output TokenReady_o, SrcReady_o, FlitValid_o, FlitData_o, Busy_o, Seq_o, Underrun_o,
           Overlap_o
  );

  // Scheduler / source / NoC side.
  modport master (
    output TokenValid_i, Id_i, SrcValid_i, SrcData_i, FlitReady_i,
    input  TokenReady_o, SrcReady_o, FlitValid_o, FlitData_o, Busy_o, Seq_o, Underrun_o,
           Overlap_o
  );
endinterface

// File: rtl/token_injector.sv
// Per-node token consumer: on a scheduler grant, injects one head + PAYLOAD_LEN body flits
// into the NoC, padding on source starvation, then releases the token.
module token_injector #(
  parameter int unsigned FLIT_W      = 32,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter logic [3:0]  SINK_ID     = 4'hF,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic             clk,
  input logic             rstn,
  token_injector_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHead, StBody, StRels} state_e;

  localparam logic [7:0]  LenB   = 8'(PAYLOAD_LEN);
  localparam logic [7:0]  LenM1  = 8'(PAYLOAD_LEN - 1);
  localparam logic [15:0] TmoM1  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  TyHead = 2'b01;
  localparam logic [1:0]  TyBody = 2'b00;
  localparam logic [1:0]  TyTail = 2'b10;

  state_e            state_q, state_d;
  logic              flit_valid_q, flit_valid_d;
  logic [FLIT_W+1:0] flit_data_q, flit_data_d;
  logic [7:0]        body_cnt_q, body_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [15:0]       seq_q, seq_d;
  logic              token_ready_q, token_ready_d;
  logic              underrun_q, underrun_d;
  logic              overlap_q, overlap_d;

  logic flit_fire, free, need_body, src_ready, tmo_tick, pad;

  always_comb begin
    flit_fire = flit_valid_q & bus.FlitReady_i;
    free      = ~flit_valid_q | bus.FlitReady_i;
    need_body = (body_cnt_q < LenB);
    // The first body word may load in the same cycle the head leaves, keeping flits back to back.
    src_ready = ((state_q == StBody) || (state_q == StHead)) & free & bus.SrcValid_i & need_body;
    tmo_tick  = (state_q == StBody) & free & ~bus.SrcValid_i & need_body;
    pad       = tmo_tick & (tmo_cnt_q == TmoM1);

    state_d       = state_q;
    flit_valid_d  = flit_valid_q;
    flit_data_d   = flit_data_q;
    body_cnt_d    = body_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    seq_d         = seq_q;
    token_ready_d = 1'b0;
    underrun_d    = underrun_q;
    overlap_d     = overlap_q;

    unique case (state_q)
      StIdle: begin
        if (bus.TokenValid_i) begin
          state_d      = StHead;
          flit_valid_d = 1'b1;
          flit_data_d  = {TyHead, FLIT_W'({seq_q, LenB, SINK_ID, bus.Id_i})};
          body_cnt_d   = 8'd0;
          tmo_cnt_d    = 16'd0;
        end
      end
      StHead: begin
        if (flit_fire) begin
          state_d      = StBody;
          flit_valid_d = 1'b0;
        end
      end
      StBody: begin
        if (flit_fire) begin
          flit_valid_d = 1'b0;
          if (flit_data_q[FLIT_W+1:FLIT_W] == TyTail) begin
            state_d       = StRels;
            token_ready_d = 1'b1;
            seq_d         = seq_q + 16'd1;
          end
        end
      end
      StRels: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (src_ready || pad) begin
      flit_valid_d = 1'b1;
      flit_data_d  = {(body_cnt_q == LenM1) ? TyTail : TyBody,
                      pad ? {FLIT_W{1'b0}} : bus.SrcData_i};
      body_cnt_d   = body_cnt_q + 8'd1;
      tmo_cnt_d    = 16'd0;
      if (pad) underrun_d = 1'b1;
    end else if (tmo_tick) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    if (bus.TokenValid_i && (state_q != StIdle)) overlap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      flit_valid_q  <= 1'b0;
      flit_data_q   <= '0;
      body_cnt_q    <= 8'd0;
      tmo_cnt_q     <= 16'd0;
      seq_q         <= 16'd0;
      token_ready_q <= 1'b0;
      underrun_q    <= 1'b0;
      overlap_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flit_valid_q  <= flit_valid_d;
      flit_data_q   <= flit_data_d;
      body_cnt_q    <= body_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      seq_q         <= seq_d;
      token_ready_q <= token_ready_d;
      underrun_q    <= underrun_d;
      overlap_q     <= overlap_d;
    end
  end

  assign bus.TokenReady_o = token_ready_q;
  assign bus.SrcReady_o   = src_ready;
  assign bus.FlitValid_o  = flit_valid_q;
  assign bus.FlitData_o   = flit_data_q;
  assign bus.Busy_o       = (state_q != StIdle);
  assign bus.Seq_o        = seq_q;
  assign bus.Underrun_o   = underrun_q;
  assign bus.Overlap_o    = overlap_q;

endmodule

// File: tb/tb_token_injector.sv
// Directed and randomized checks of token_injector against a packet-level reference model.
module tb_token_injector;
  localparam int unsigned FW  = 32;
  localparam int unsigned LEN = 4;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  token_injector_if #(.FLIT_W(FW)) bus ();

  token_injector #(
    .FLIT_W     (FW),
    .PAYLOAD_LEN(LEN),
    .SINK_ID    (4'hF),
    .TIMEOUT    (TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [33:0] flits[$];
  logic [31:0] src_mem[256];
  int          rel_cnt = 0;
  int          src_pos = 0;
  int          src_avail = 256;
  int          src_gap = 0;
  bit          src_rand = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          rdy_low = 1'b0;
  logic [15:0] exp_seq = 16'd0;

  logic        s_fv, s_sr, s_tr;
  logic [33:0] s_fd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, sample mid-cycle, return just after the next rising edge.
  task automatic step(input logic grant = 1'b0);
    logic v;
    bus.TokenValid_i = grant;
    v = 1'b1;
    if (src_rand) begin
      v = ($urandom_range(0, 3) != 0) || (src_gap >= 3);
      src_gap = v ? 0 : src_gap + 1;
    end
    bus.SrcValid_i  = v && (src_pos < src_avail);
    bus.SrcData_i   = src_mem[src_pos[7:0]];
    bus.FlitReady_i = rdy_low ? 1'b0 : (rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
    @(negedge clk);
    s_fv = bus.FlitValid_o;
    s_fd = bus.FlitData_o;
    s_sr = bus.SrcReady_o;
    s_tr = bus.TokenReady_o;
    if (s_fv && bus.FlitReady_i) flits.push_back(s_fd);
    if (s_sr) src_pos++;
    if (s_tr) rel_cnt++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] head_flit(input logic [3:0] id, input logic [15:0] seq);
    return {2'b01, seq, 8'(LEN), 4'hF, id};
  endfunction

  function automatic logic [33:0] body_flit(input int k, input logic [31:0] d);
    return {(k == int'(LEN) - 1) ? 2'b10 : 2'b00, d};
  endfunction

  task automatic drain(input string tag, input int rel0);
    int n;
    n = 0;
    while (rel_cnt == rel0 && n < 200) begin
      step();
      n++;
    end
    step();
    chk({tag, "_release_count"}, 64'(rel_cnt - rel0), 64'd1);
  endtask

  // Expected packet: head, then nreal consumed source words, then zero pads.
  task automatic check_packet(input string tag, input logic [3:0] id, input logic [15:0] seq,
                              input int base, input int nreal);
    logic [31:0] d;
    chk({tag, "_flit_count"}, 64'(flits.size()), 64'(LEN + 1));
    if (flits.size() == int'(LEN) + 1) begin
      chk({tag, "_head"}, 64'(flits[0]), 64'(head_flit(id, seq)));
      for (int k = 0; k < int'(LEN); k++) begin
        d = (k < nreal) ? src_mem[8'(base + k)] : 32'd0;
        chk({tag, "_body"}, 64'(flits[k+1]), 64'(body_flit(k, d)));
      end
    end
  endtask

  initial begin
    int base, r0, cnt;
    logic [3:0] id;

    bus.TokenValid_i = 1'b0;
    bus.Id_i         = 4'd0;
    bus.SrcValid_i   = 1'b0;
    bus.SrcData_i    = '0;
    bus.FlitReady_i  = 1'b0;
    for (int i = 0; i < 256; i++) src_mem[i] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_flit_valid", 64'(bus.FlitValid_o), 64'd0);
    chk("reset_token_ready", 64'(bus.TokenReady_o), 64'd0);
    chk("reset_seq", 64'(bus.Seq_o), 64'd0);
    chk("reset_flags", 64'({bus.Underrun_o, bus.Overlap_o, bus.Busy_o}), 64'd0);
    rstn = 1'b1;
    step();

    // Basic packet, fully ready.
    base = src_pos;
    for (int k = 0; k < 4; k++) src_mem[8'(base + k)] = 32'hA0 + 32'(k);
    flits.delete();
    r0 = rel_cnt;
    bus.Id_i = 4'd3;
    step(1'b1);
    chk("basic_c0_valid", 64'(s_fv), 64'd0);
    step();
    chk("basic_c1_head", 64'({s_fv, s_fd}), 64'({1'b1, 34'h0_0004_F3 | {2'b01, 32'd0}}));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("basic_body_cycle", 64'({s_fv, s_fd}), 64'({1'b1, body_flit(k, 32'hA0 + 32'(k))}));
    end
    step();
    chk("basic_c6_release", 64'(s_tr), 64'd1);
    step();
    chk("basic_c7_release_low", 64'(s_tr), 64'd0);
    exp_seq = exp_seq + 16'd1;
    chk("basic_seq", 64'(bus.Seq_o), 64'(exp_seq));
    chk("basic_release_count", 64'(rel_cnt - r0), 64'd1);
    check_packet("basic", 4'd3, 16'd0, base, 4);

    // Backpressure while body 0xA1 is presented.
    base = src_pos;
    for (int k = 0; k < 4; k++) src_mem[8'(base + k)] = 32'hA0 + 32'(k);
    flits.delete();
    r0 = rel_cnt;
    bus.Id_i = 4'd5;
    step(1'b1);
    step();
    step();
    rdy_low = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_stall_flit", 64'({s_fv, s_fd}), 64'({1'b1, 2'b00, 32'hA1}));
      chk("bp_stall_src_ready", 64'(s_sr), 64'd0);
    end
    rdy_low = 1'b0;
    drain("bp", r0);
    check_packet("bp", 4'd5, exp_seq, base, 4);
    exp_seq = exp_seq + 16'd1;
    chk("bp_seq", 64'(bus.Seq_o), 64'(exp_seq));

    // Starvation: two words then silence; two pads spaced TMO cycles apart.
    base = src_pos;
    src_avail = src_pos + 2;
    flits.delete();
    r0 = rel_cnt;
    bus.Id_i = 4'd9;
    chk("starve_underrun_before", 64'(bus.Underrun_o), 64'd0);
    step(1'b1);
    step();
    step();
    step();
    cnt = 0;
    for (int c = 4; c <= 10; c++) begin
      step();
      if (s_fv) cnt++;
    end
    chk("starve_gap1_valid_cycles", 64'(cnt), 64'd0);
    step();
    chk("starve_pad1", 64'({s_fv, s_fd}), 64'({1'b1, 34'd0}));
    cnt = 0;
    for (int c = 12; c <= 18; c++) begin
      step();
      if (s_fv) cnt++;
    end
    chk("starve_gap2_valid_cycles", 64'(cnt), 64'd0);
    step();
    chk("starve_pad2_tail", 64'({s_fv, s_fd}), 64'({1'b1, 2'b10, 32'd0}));
    step();
    chk("starve_release", 64'(s_tr), 64'd1);
    step();
    src_avail = 256;
    chk("starve_release_count", 64'(rel_cnt - r0), 64'd1);
    chk("starve_underrun", 64'(bus.Underrun_o), 64'd1);
    check_packet("starve", 4'd9, exp_seq, base, 2);
    exp_seq = exp_seq + 16'd1;

    // Overlapping grants in BODY and in RELS.
    base = src_pos;
    flits.delete();
    r0 = rel_cnt;
    bus.Id_i = 4'd7;
    chk("ovl_flag_before", 64'(bus.Overlap_o), 64'd0);
    step(1'b1);
    step();
    step();
    bus.Id_i = 4'd2;
    step(1'b1);
    step();
    step();
    step(1'b1);
    chk("ovl_release_in_rels", 64'(s_tr), 64'd1);
    repeat (4) step();
    chk("ovl_release_count", 64'(rel_cnt - r0), 64'd1);
    chk("ovl_idle_after", 64'(bus.Busy_o), 64'd0);
    chk("ovl_flag", 64'(bus.Overlap_o), 64'd1);
    check_packet("ovl", 4'd7, exp_seq, base, 4);
    exp_seq = exp_seq + 16'd1;

    // Randomized source validity and NoC backpressure.
    src_rand = 1'b1;
    rdy_rand = 1'b1;
    for (int p = 0; p < 12; p++) begin
      id = 4'($urandom_range(0, 15));
      bus.Id_i = id;
      base = src_pos;
      flits.delete();
      r0 = rel_cnt;
      step(1'b1);
      drain("rand", r0);
      check_packet("rand", id, exp_seq, base, 4);
      exp_seq = exp_seq + 16'd1;
      chk("rand_seq", 64'(bus.Seq_o), 64'(exp_seq));
    end
    src_rand = 1'b0;
    rdy_rand = 1'b0;

    // Reset in the middle of a packet.
    bus.Id_i = 4'd2;
    r0 = rel_cnt;
    step(1'b1);
    repeat (3) step();
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_flit_valid_now", 64'(bus.FlitValid_o), 64'd0);
    chk("rst_seq", 64'(bus.Seq_o), 64'd0);
    chk("rst_flags", 64'({bus.Underrun_o, bus.Overlap_o, bus.Busy_o}), 64'd0);
    exp_seq = 16'd0;
    @(posedge clk);
    #1;
    repeat (2) step();
    chk("rst_no_release", 64'(rel_cnt - r0), 64'd0);
    rstn = 1'b1;
    step();
    base = src_pos;
    flits.delete();
    r0 = rel_cnt;
    bus.Id_i = 4'd6;
    step(1'b1);
    drain("post_rst", r0);
    check_packet("post_rst", 4'd6, 16'd0, base, 4);
    exp_seq = exp_seq + 16'd1;

    // Sequence counter wrap.
    force dut.seq_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.seq_q;
    exp_seq = 16'hFFFF;
    chk("wrap_preload", 64'(bus.Seq_o), 64'(exp_seq));
    base = src_pos;
    flits.delete();
    r0 = rel_cnt;
    bus.Id_i = 4'd1;
    step(1'b1);
    drain("wrap", r0);
    check_packet("wrap", 4'd1, 16'hFFFF, base, 4);
    exp_seq = exp_seq + 16'd1;
    chk("wrap_seq", 64'(bus.Seq_o), 64'(exp_seq));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/token_injector.md
Name: token_injector

Overview:
- Per-node consumer of the boot scheduler's token grant, one instance per logic node, index i.
- A single-cycle TokenValid_i grant makes the block send one packet into the NoC injection port. The packet is one head flit, PAYLOAD_LEN body flits taken from the local sample source, and the tail marked on the last flit.
- When the tail is accepted, the block pulses TokenReady_o so the scheduler can advance to the next node.
- A source-starvation timeout pads the packet so the token ring never deadlocks.

Parameters:
- FLIT_W, 32, data bits per flit; the flit bus is FLIT_W+2 wide including the 2-bit type field.
- PAYLOAD_LEN, 4, body flits per packet; legal range 1..255.
- SINK_ID, 4'hF, destination node ID written into the head flit.
- TIMEOUT, 1024, idle source cycles in BODY before a zero pad flit is inserted; legal range 1..65535.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- TokenValid_i, input, 1, token grant pulse from the scheduler.
- TokenReady_o, output, 1, token release pulse (packet done).
- Id_i, input, 4, node ID from the scheduler; sampled on the grant.
- SrcValid_i, input, 1, sample word available.
- SrcData_i, input, FLIT_W, sample word.
- SrcReady_o, output, 1, sample word consumed this cycle.
- FlitValid_o, output, 1, NoC flit valid.
- FlitData_o, output, FLIT_W+2, flit; bits [FLIT_W+1:FLIT_W] are the type: 01 head, 00 body, 10 tail.
- FlitReady_i, input, 1, NoC accepts the flit.
- Busy_o, output, 1, state is not IDLE.
- Seq_o, output, 16, count of completed packets.
- Underrun_o, output, 1, sticky: at least one pad flit has been sent.
- Overlap_o, output, 1, sticky: a grant arrived while busy.

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - All outputs 0, including FlitValid_o, TokenReady_o, Seq_o and both sticky flags.
  - Counters 0.
  - A reset mid-packet drops the packet silently; no tail and no release pulse.
- States: IDLE, HEAD, BODY, RELS.
- IDLE:
  - On TokenValid_i, latch Id_i and go to HEAD in the next cycle.
  - TokenReady_o stays 0 in IDLE, so the scheduler never sees a spurious release.
- HEAD:
  - Flit register loads with type 01.
  - Head data fields: [3:0] latched ID, [7:4] SINK_ID, [15:8] PAYLOAD_LEN, [31:16] Seq_o, remaining bits 0.
  - FlitValid_o rises one cycle after the grant.
  - Go to BODY on the cycle FlitValid_o & FlitReady_i.
- BODY:
  - Flit register is free when it is empty or is being accepted this cycle.
  - SrcReady_o = free & SrcValid_i & body count < PAYLOAD_LEN. A word transfers on SrcReady_o.
  - The transferred word loads the flit register: type 10 if it is the PAYLOAD_LEN-th body flit, else 00.
  - A flit register stalled by FlitReady_i=0 holds its data and valid stable; no source word is consumed while stalled.
- Timeout:
  - Counter counts BODY cycles where the register is free and SrcValid_i=0.
  - On reaching TIMEOUT, load a zero-data flit with the correct type, set Underrun_o, clear the counter.
  - Counter also clears on every source transfer.
  - Pad flits count toward PAYLOAD_LEN.
- Tail: when the tail flit is accepted (FlitValid_o & FlitReady_i with type 10), go to RELS.
- RELS:
  - TokenReady_o=1 for exactly one cycle.
  - Seq_o increments by 1, mod 2^16 (0xFFFF wraps to 0x0000).
  - Return to IDLE.
- Grant while not IDLE: ignored, Overlap_o set; the packet in flight is unaffected.
- Grant in the same cycle RELS exits: treated as busy, so ignored and flagged.
- Throughput: with FlitReady_i and SrcValid_i held high, a packet takes one grant cycle, one head, PAYLOAD_LEN body flits back to back, then one RELS cycle.
- Busy_o = (state != IDLE).
- Body count and timeout counter are internal and clear on each grant.

Test Plan:
- Basic packet: Id_i=3, grant pulse, source and NoC always ready, PAYLOAD_LEN=4, source words 0xA0..0xA3.
  - Required: head 0x0_0004_F3 type 01 at cycle 1; bodies 0xA0, 0xA1, 0xA2 type 00; 0xA3 type 10.
  - Required: TokenReady_o pulse at cycle 6 (RELS); Seq_o=1.
- Backpressure: FlitReady_i low for 3 cycles while body 0xA1 is presented.
  - Required: FlitData_o and FlitValid_o stable for all 3 cycles; SrcReady_o=0 for those cycles; no word lost or duplicated.
- Starvation: TIMEOUT=8, source supplies 2 words then stops.
  - Required: after 8 idle cycles one zero pad flit is sent, then another 8 cycles later; the second pad is type 10.
  - Required: Underrun_o=1; TokenReady_o pulses once.
- Overlap: second grant during BODY, and another grant in the RELS cycle.
  - Required: packet unchanged, Overlap_o=1, exactly one release pulse.
- Reset mid-packet: assert rstn=0 during BODY.
  - Required: FlitValid_o=0 immediately; no TokenReady_o pulse; Seq_o=0.
  - Required: the next grant after reset produces a full packet with head seq 0.
- Seq wrap: preload Seq_o to 0xFFFF via 65535 packets (or force), run one packet.
  - Required: head carries 0xFFFF; Seq_o becomes 0x0000 afterwards.
